// File: rtl/mem_access_ctrl_if.sv
// Pipeline MEM-stage request plus data-cache bus seen by the memory access controller.
// slave = the controller, master = the pipeline/cache side that drives its inputs.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        dcacheR;
    logic        dcacheW;
    logic        ldi_op;
    logic        sti_op;
    logic        ldb_op;
    logic        stb_op;
    logic [15:0] mem_addr;
    logic [15:0] store_data;
    logic        dcache_read;
    logic        dcache_write;
    logic [15:0] dcache_address;
    logic [15:0] dcache_wdata;
    logic [1:0]  dcache_wmask;
    logic [15:0] dcache_rdata;
    logic        dcache_resp;
    logic [15:0] mem_rdata;
    logic        stall;

    modport slave (
        input  req_valid, dcacheR, dcacheW, ldi_op, sti_op, ldb_op, stb_op,
        input  mem_addr, store_data, dcache_rdata, dcache_resp,
        output dcache_read, dcache_write, dcache_address, dcache_wdata,
        output dcache_wmask, mem_rdata, stall
    );

    modport master (
        output req_valid, dcacheR, dcacheW, ldi_op, sti_op, ldb_op, stb_op,
        output mem_addr, store_data, dcache_rdata, dcache_resp,
        input  dcache_read, dcache_write, dcache_address, dcache_wdata,
        input  dcache_wmask, mem_rdata, stall
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// LC-3b MEM-stage controller: sequences word/byte/indirect loads and stores onto the
// data cache and stalls the pipeline until the access finishes.
module mem_access_ctrl (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PTR, DATA, DONE} state_t;

    state_t      r_state;
    logic        r_rd;
    logic        r_wr;
    logic        r_ind;
    logic        r_byte;
    logic        r_abort;
    logic [15:0] r_addr;
    logic [15:0] r_sdata;
    logic [15:0] r_ptr;
    logic [15:0] r_mem_rdata;

    logic        w_mem_op;
    logic        w_abort;
    logic [15:0] w_base;
    logic        w_read;
    logic        w_write;
    logic [15:0] w_address;
    logic [15:0] w_wdata;
    logic [1:0]  w_wmask;

    assign w_mem_op = bus.req_valid & (bus.dcacheR | bus.dcacheW);
    // Once the request disappears mid-access we still finish the cache cycle, then drop it.
    assign w_abort  = r_abort | ~bus.req_valid;
    assign w_base   = r_ind ? r_ptr : r_addr;

    // Cache-side outputs decode only registered state, so they hold steady for the
    // whole access and fall to zero the instant reset clears the state.
    always_comb begin
        w_read    = 1'b0;
        w_write   = 1'b0;
        w_address = 16'h0000;
        w_wdata   = 16'h0000;
        w_wmask   = 2'b00;
        case (r_state)
            PTR: begin
                w_read    = 1'b1;
                w_address = {r_addr[15:1], 1'b0};
            end
            DATA: begin
                w_read  = r_rd;
                w_write = r_wr;
                if (r_byte) begin
                    w_address = w_base;
                    w_wdata   = {r_sdata[7:0], r_sdata[7:0]};
                    w_wmask   = w_base[0] ? 2'b10 : 2'b01;
                end else begin
                    w_address = {w_base[15:1], 1'b0};
                    w_wdata   = r_sdata;
                    w_wmask   = 2'b11;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_ind       <= 1'b0;
            r_byte      <= 1'b0;
            r_abort     <= 1'b0;
            r_addr      <= 16'h0000;
            r_sdata     <= 16'h0000;
            r_ptr       <= 16'h0000;
            r_mem_rdata <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mem_op) begin
                        r_rd    <= bus.dcacheR;
                        r_wr    <= bus.dcacheW;
                        r_ind   <= bus.ldi_op | bus.sti_op;
                        r_byte  <= bus.ldb_op | bus.stb_op;
                        r_addr  <= bus.mem_addr;
                        r_sdata <= bus.store_data;
                        r_abort <= 1'b0;
                        r_state <= (bus.ldi_op | bus.sti_op) ? PTR : DATA;
                    end
                end
                PTR: begin
                    r_abort <= w_abort;
                    if (bus.dcache_resp) begin
                        r_ptr   <= bus.dcache_rdata;
                        r_state <= w_abort ? IDLE : DATA;
                    end
                end
                DATA: begin
                    r_abort <= w_abort;
                    if (bus.dcache_resp) begin
                        if (w_abort) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= DONE;
                            if (r_rd) begin
                                if (r_byte)
                                    r_mem_rdata <= w_base[0] ? {8'h00, bus.dcache_rdata[15:8]}
                                                             : {8'h00, bus.dcache_rdata[7:0]};
                                else
                                    r_mem_rdata <= bus.dcache_rdata;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.dcache_read    = w_read;
    assign bus.dcache_write   = w_write;
    assign bus.dcache_address = w_address;
    assign bus.dcache_wdata   = w_wdata;
    assign bus.dcache_wmask   = w_wmask;
    assign bus.mem_rdata      = r_mem_rdata;
    // Reset must release the pipeline at once even while an op is still presented.
    assign bus.stall          = rst_n & w_mem_op & (r_state != DONE);
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: the bench plays pipeline and data cache and
// predicts every cache access and load result from the addressing rules.
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl_if bus();

    mem_access_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_rdata = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // op: 0 LDR, 1 STR, 2 LDB, 3 STB, 4 LDI, 5 STI
    task automatic set_op(input int op, input logic [15:0] addr, input logic [15:0] sdata);
        bus.req_valid   = 1'b1;
        bus.dcacheR     = (op == 0 || op == 2 || op == 4);
        bus.dcacheW     = (op == 1 || op == 3 || op == 5);
        bus.ldi_op      = (op == 4);
        bus.sti_op      = (op == 5);
        bus.ldb_op      = (op == 2);
        bus.stb_op      = (op == 3);
        bus.mem_addr    = addr;
        bus.store_data  = sdata;
        bus.dcache_resp = 1'b0;
    endtask

    task automatic clear_op();
        bus.req_valid  = 1'b0;
        bus.dcacheR    = 1'b0;
        bus.dcacheW    = 1'b0;
        bus.ldi_op     = 1'b0;
        bus.sti_op     = 1'b0;
        bus.ldb_op     = 1'b0;
        bus.stb_op     = 1'b0;
        bus.mem_addr   = 16'h0000;
        bus.store_data = 16'h0000;
    endtask

    // One cache access answered after lat cycles; strobes checked every cycle.
    task automatic access_phase(input string ph, input bit rd, input bit wr,
                                input logic [15:0] addr, input logic [1:0] wm,
                                input logic [15:0] wd, input bit chk_data,
                                input int lat, input logic [15:0] rdata);
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk); #1;
            bus.dcache_resp  = (c == lat);
            bus.dcache_rdata = (c == lat) ? rdata : 16'($urandom);
            @(negedge clk);
            chk({ph, "_read"}, bus.dcache_read, rd);
            chk({ph, "_write"}, bus.dcache_write, wr);
            chk({ph, "_addr"}, bus.dcache_address, addr);
            chk({ph, "_stall"}, bus.stall, 1);
            if (chk_data) begin
                chk({ph, "_wmask"}, bus.dcache_wmask, wm);
                if (wr) chk({ph, "_wdata"}, bus.dcache_wdata, wd);
            end
        end
    endtask

    task automatic run_op(input int op, input logic [15:0] addr, input logic [15:0] sdata,
                          input int lat1, input logic [15:0] r1,
                          input int lat2, input logic [15:0] r2);
        bit          ind, byt, isrd, iswr;
        logic [15:0] base, daddr, wd;
        logic [1:0]  wm;
        ind  = (op >= 4);
        byt  = (op == 2 || op == 3);
        isrd = (op == 0 || op == 2 || op == 4);
        iswr = !isrd;
        @(posedge clk); #1;
        set_op(op, addr, sdata);
        @(negedge clk);
        chk("idle_stall", bus.stall, 1);
        chk("idle_strobe", {bus.dcache_read, bus.dcache_write}, 0);
        chk("idle_rdata", bus.mem_rdata, exp_rdata);
        base = addr;
        if (ind) begin
            access_phase("ptr", 1'b1, 1'b0, addr & 16'hFFFE, 2'b00, 16'h0000, 1'b0, lat1, r1);
            base = r1;
        end
        daddr = byt ? base : (base & 16'hFFFE);
        wm    = byt ? ((base % 2 == 1) ? 2'b10 : 2'b01) : 2'b11;
        wd    = byt ? 16'((sdata & 16'h00FF) * 16'h0101) : sdata;
        access_phase("data", isrd, iswr, daddr, wm, wd, 1'b1, lat2, r2);
        if (isrd)
            exp_rdata = byt ? ((base % 2 == 1) ? (r2 >> 8) : (r2 & 16'h00FF)) : r2;
        @(posedge clk); #1;
        bus.dcache_resp  = 1'($urandom % 2);
        bus.dcache_rdata = 16'($urandom);
        @(negedge clk);
        chk("done_stall", bus.stall, 0);
        chk("done_strobe", {bus.dcache_read, bus.dcache_write}, 0);
        chk("done_rdata", bus.mem_rdata, exp_rdata);
        $display("op=%0d addr=%h sdata=%h data_addr=%h mem_rdata=%h", op, addr, sdata, daddr, bus.mem_rdata);
    endtask

    initial begin
        clear_op();
        bus.dcache_resp  = 1'b0;
        bus.dcache_rdata = 16'h0000;
        #2;
        chk("rst_stall", bus.stall, 0);
        chk("rst_strobe", {bus.dcache_read, bus.dcache_write}, 0);
        chk("rst_addr", bus.dcache_address, 0);
        chk("rst_rdata", bus.mem_rdata, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 16'h3001, 16'h0000, 0, 16'h0000, 3, 16'hBEEF);
        run_op(2, 16'h4003, 16'h0000, 0, 16'h0000, 1, 16'hA55A);
        run_op(2, 16'h4002, 16'h0000, 0, 16'h0000, 2, 16'hA55A);
        run_op(3, 16'h5001, 16'h1234, 0, 16'h0000, 1, 16'h0000);
        run_op(1, 16'h5001, 16'h1234, 0, 16'h0000, 2, 16'h0000);
        run_op(4, 16'h6000, 16'h0000, 2, 16'h7002, 2, 16'h0042);
        run_op(5, 16'h6000, 16'hCAFE, 1, 16'h7002, 3, 16'h0000);

        // Spurious response while idle with no op.
        @(posedge clk); #1;
        clear_op();
        bus.dcache_resp = 1'b1;
        @(negedge clk);
        chk("spur_stall", bus.stall, 0);
        chk("spur_strobe", {bus.dcache_read, bus.dcache_write}, 0);
        run_op(0, 16'h0100, 16'h0000, 0, 16'h0000, 1, 16'h1111);

        // Request withdrawn mid-access: cache cycle completes, no result, straight to IDLE.
        @(posedge clk); #1;
        set_op(0, 16'h1235, 16'h0000);
        @(negedge clk);
        chk("abort_idle_stall", bus.stall, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_read0", bus.dcache_read, 1);
        @(posedge clk); #1;
        clear_op();
        @(negedge clk);
        chk("abort_read1", bus.dcache_read, 1);
        chk("abort_addr", bus.dcache_address, 16'h1234);
        chk("abort_stall", bus.stall, 0);
        @(posedge clk); #1;
        bus.dcache_resp  = 1'b1;
        bus.dcache_rdata = 16'hFFFF;
        @(negedge clk);
        chk("abort_read2", bus.dcache_read, 1);
        run_op(0, 16'h2222, 16'h0000, 0, 16'h0000, 2, 16'h2468);

        // Reset during the DATA phase of an STI.
        @(posedge clk); #1;
        set_op(5, 16'h6000, 16'h5555);
        @(negedge clk);
        @(posedge clk); #1;
        bus.dcache_resp  = 1'b1;
        bus.dcache_rdata = 16'h7002;
        @(negedge clk);
        chk("rsti_ptr_addr", bus.dcache_address, 16'h6000);
        @(posedge clk); #1;
        bus.dcache_resp = 1'b0;
        @(negedge clk);
        chk("rsti_write", bus.dcache_write, 1);
        chk("rsti_addr", bus.dcache_address, 16'h7002);
        #2 rst_n = 1'b0;
        #1;
        chk("rsti_write_rst", bus.dcache_write, 0);
        chk("rsti_stall_rst", bus.stall, 0);
        chk("rsti_addr_rst", bus.dcache_address, 0);
        chk("rsti_wdata_rst", bus.dcache_wdata, 0);
        chk("rsti_wmask_rst", bus.dcache_wmask, 0);
        chk("rsti_rdata_rst", bus.mem_rdata, 0);
        exp_rdata = 16'h0000;
        @(posedge clk); #1;
        clear_op();
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4, 16'h0F00, 16'h0000, 1, 16'h1357, 1, 16'h9ABC);

        for (int i = 0; i < 80; i++) begin
            run_op(int'($urandom % 6), 16'($urandom), 16'($urandom),
                   1 + int'($urandom % 3), 16'($urandom),
                   1 + int'($urandom % 4), 16'($urandom));
            if ($urandom % 3 == 0) begin
                @(posedge clk); #1;
                clear_op();
                bus.dcache_resp = 1'($urandom % 2);
                @(negedge clk);
                chk("gap_stall", bus.stall, 0);
                chk("gap_strobe", {bus.dcache_read, bus.dcache_write}, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
